sync_fifo_prog: RTL and testbench
=================================

SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

Interface
REQ-001 The block SHALL have the parameter FIFO_WIDTH, default 16, data word width in bits (1..64).
REQ-002 The block SHALL have the parameter FIFO_DEPTH, default 8, number of entries (2..1024, any integer, not restricted to powers of two).
REQ-003 The block SHALL have the parameter FWFT, default 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have the following ports, with LW = $clog2(FIFO_DEPTH+1):
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- data_in  input  FIFO_WIDTH  write data.
- wr_en  input  1  write request.
- rd_en  input  1  read request (pop).
- af_thresh  input  LW  almost-full threshold, sampled every cycle.
- ae_thresh  input  LW  almost-empty threshold, sampled every cycle.
- data_out  output  FIFO_WIDTH  read data.
- rd_valid  output  1  data_out holds valid popped/head data.
- wr_ack  output  1  previous-cycle write accepted.
- overflow  output  1  previous-cycle write rejected.
- underflow  output  1  previous-cycle read rejected.
- full  output  1  level == FIFO_DEPTH.
- empty  output  1  level == 0.
- almostfull  output  1  level >= af_thresh.
- almostempty  output  1  level <= ae_thresh.
- level  output  LW  current occupancy.

Function
REQ-006 A write SHALL be accepted when wr_en=1 and (!full, or rd_en=1 with the read accepted); data_in is stored at wr_ptr.
REQ-007 A read SHALL be accepted when rd_en=1 and !empty.
REQ-008 When full, wr_en=1 and rd_en=1, both the write and the read SHALL be accepted and level SHALL stay at FIFO_DEPTH.
REQ-009 When empty, wr_en=1 and rd_en=1, the write SHALL be accepted, the read rejected, level SHALL become 1, and underflow SHALL be set.
REQ-010 level SHALL be updated as follows: +1 on write-only accept, -1 on read-only accept, unchanged otherwise.
REQ-011 level SHALL never exceed FIFO_DEPTH or go below 0.
REQ-012 wr_ptr and rd_ptr SHALL wrap from FIFO_DEPTH-1 to 0.
REQ-013 wr_ack, overflow and underflow SHALL be registered one-cycle pulses, asserted in the cycle after the request and cleared when there is no new event.
REQ-014 wr_ack and overflow SHALL be mutually exclusive.
REQ-015 full, empty, almostfull, almostempty and level SHALL be combinational from the registered level.
REQ-016 FWFT=0: on an accepted read, data_out SHALL load mem[rd_ptr] at the next edge and rd_valid SHALL pulse for 1 cycle; otherwise data_out SHALL hold its value and rd_valid SHALL be 0.
REQ-017 FWFT=1: data_out SHALL present the head entry, rd_valid = !empty, and rd_en SHALL pop it.
REQ-018 FWFT=1: a word written into an empty FIFO SHALL appear on data_out with rd_valid=1 in the cycle after the write.
REQ-019 The threshold outputs SHALL follow changes to af_thresh and ae_thresh without a cycle of delay.
REQ-020 af_thresh=0 SHALL force almostfull=1.
REQ-021 ae_thresh >= FIFO_DEPTH SHALL force almostempty=1.

Reset
REQ-022 With rst=1 at a clock edge, wr_ptr, rd_ptr and level SHALL be set to 0, and wr_ack, overflow, underflow and rd_valid SHALL be set to 0.
REQ-023 During and after reset, data_out SHALL be 0; empty=1 and full=0.
REQ-024 Reset SHALL take priority over simultaneous wr_en and rd_en.
REQ-025 Memory contents SHALL NOT be cleared by reset.
REQ-026 A reset asserted mid-operation SHALL discard all stored words; the first post-reset write SHALL be the next word read.

Structure
REQ-027 The package fifo_pkg SHALL hold the read-mode constants FWFT_OFF and FWFT_ON and a function computing LW from a depth.
REQ-028 Storage SHALL be the sub-module fifo_mem: parameterised FIFO_WIDTH x FIFO_DEPTH, one synchronous write port, and one asynchronous read port.
REQ-029 Pointer, level and flag logic SHALL reside in sync_fifo_prog.
REQ-030 The block SHALL contain immediate/concurrent assertions for REQ-008, REQ-011, REQ-013 and REQ-014.

Verification
REQ-031 The bench SHALL cover, with DEPTH=8, WIDTH=16, FWFT=0: after reset, 8 writes of 0x0001..0x0008 -> wr_ack pulses 8 times, full=1, level=8; a 9th write -> overflow=1 and wr_ack=0 next cycle.
REQ-032 The bench SHALL cover, at full: wr_en=rd_en=1 with data 0x00AA -> data_out=0x0001 next cycle, level=8, no overflow; after 8 further reads the last data_out is 0x00AA.
REQ-033 The bench SHALL cover, at empty: wr_en=rd_en=1 with data 0x0055 -> underflow=1, level=1; the next read returns 0x0055.
REQ-034 The bench SHALL cover, with DEPTH=5 (non-power-of-two): 12 interleaved writes and reads -> pointers wrap, data order is preserved, and level never exceeds 5.
REQ-035 The bench SHALL cover, with FWFT=1: a write of 0x1234 to an empty FIFO -> next cycle data_out=0x1234 and rd_valid=1 with no rd_en; rd_en=1 -> empty=1 and rd_valid=0 next cycle.
REQ-036 The bench SHALL cover, with af_thresh=6 and ae_thresh=2: fill to level 6 -> almostfull=1; change af_thresh to 7 -> almostfull=0 the same cycle; rst=1 mid-fill -> level=0 next cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the programmable synchronous FIFO.
package fifo_pkg;

    // Read-mode selectors for the FWFT parameter
    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    // Width of an occupancy count able to hold 0..depth inclusive
    function automatic int calc_lw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the pointers define what is valid.
module fifo_mem #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AW         = 3
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [FIFO_WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]         i_rd_addr,
    output logic [FIFO_WIDTH-1:0] o_rd_data
);

    logic [FIFO_WIDTH-1:0] r_mem [0:FIFO_DEPTH-1];

    // Store the write word at the write address
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds,
// arbitrary (non power-of-two) depth and selectable standard / FWFT read mode.
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int FWFT       = FWFT_OFF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [FIFO_WIDTH-1:0]            data_in,
    input  logic                             wr_en,
    input  logic                             rd_en,
    input  logic [calc_lw(FIFO_DEPTH)-1:0]   af_thresh,
    input  logic [calc_lw(FIFO_DEPTH)-1:0]   ae_thresh,
    output logic [FIFO_WIDTH-1:0]            data_out,
    output logic                             rd_valid,
    output logic                             wr_ack,
    output logic                             overflow,
    output logic                             underflow,
    output logic                             full,
    output logic                             empty,
    output logic                             almostfull,
    output logic                             almostempty,
    output logic [calc_lw(FIFO_DEPTH)-1:0]   level
);

    localparam int LW = calc_lw(FIFO_DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
    localparam logic [LW-1:0] DEPTH_LV = LW'(FIFO_DEPTH);

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_wr_ack;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd_accept;
    logic                  w_wr_accept;
    logic [FIFO_WIDTH-1:0] w_mem_rd_data;

    // Status flags come straight from the registered level
    assign w_full      = (r_level == DEPTH_LV);
    assign w_empty     = (r_level == '0);
    // A write into a full FIFO is allowed only when a read frees a slot the same cycle
    assign w_rd_accept = rd_en && !w_empty;
    assign w_wr_accept = wr_en && (!w_full || w_rd_accept);

    fifo_mem #(
        .FIFO_WIDTH (FIFO_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .AW         (PW)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_accept && !rst),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data_in),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_mem_rd_data)
    );

    // Pointer and occupancy bookkeeping; pointers wrap explicitly at DEPTH-1
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd_accept) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_wr_accept && !w_rd_accept) begin
                r_level <= r_level + 1'b1;
            end else if (!w_wr_accept && w_rd_accept) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    // One-cycle event pulses describing the previous cycle's requests
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ack    <= w_wr_accept;
            r_overflow  <= wr_en && !w_wr_accept;
            r_underflow <= rd_en && !w_rd_accept;
        end
    end

    generate
        if (FWFT == FWFT_ON) begin : g_fwft
            // Head entry is always visible; masked to zero while empty
            assign data_out = w_empty ? '0 : w_mem_rd_data;
            assign rd_valid = !w_empty;
        end else begin : g_std
            logic [FIFO_WIDTH-1:0] r_data_out;
            logic                  r_rd_valid;

            // Registered read: load the head word on an accepted pop
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data_out <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_accept;
                    if (w_rd_accept) begin
                        r_data_out <= w_mem_rd_data;
                    end
                end
            end

            assign data_out = r_data_out;
            assign rd_valid = r_rd_valid;
        end
    endgenerate

    assign wr_ack      = r_wr_ack;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;
    assign full        = w_full;
    assign empty       = w_empty;
    assign almostfull  = (r_level >= af_thresh);
    assign almostempty = (r_level <= ae_thresh);
    assign level       = r_level;

    logic r_both_at_full;
    logic r_wr_en_q;
    logic r_rd_en_q;

    // History needed by the protocol checks below
    always_ff @(posedge clk) begin
        if (rst) begin
            r_both_at_full <= 1'b0;
            r_wr_en_q      <= 1'b0;
            r_rd_en_q      <= 1'b0;
        end else begin
            r_both_at_full <= w_full && wr_en && rd_en;
            r_wr_en_q      <= wr_en;
            r_rd_en_q      <= rd_en;
        end
    end

    // Protocol checks: bounded level, simultaneous op at full, pulse causality, ack/overflow exclusion
    always @(posedge clk) begin
        if (!rst) begin
            a_level_bound: assert (r_level <= DEPTH_LV);
            a_full_both:   assert (!r_both_at_full || (r_level == DEPTH_LV));
            a_ack_cause:   assert (!r_wr_ack || r_wr_en_q);
            a_ovf_cause:   assert (!r_overflow || r_wr_en_q);
            a_udf_cause:   assert (!r_underflow || r_rd_en_q);
            a_ack_ovf:     assert (!(r_wr_ack && r_overflow));
        end
    end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: depth-8 standard, depth-5 standard and depth-8 FWFT instances.
module tb_sync_fifo_prog;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // DUT A: depth 8, standard read
    logic        a_rst, a_wr, a_rd, a_rv, a_ack, a_ovf, a_udf, a_full, a_empty, a_afull, a_aempty;
    logic [15:0] a_din, a_dout;
    logic [3:0]  a_af, a_ae, a_lvl;
    // DUT B: depth 5, standard read
    logic        b_rst, b_wr, b_rd, b_rv, b_ack, b_ovf, b_udf, b_full, b_empty, b_afull, b_aempty;
    logic [15:0] b_din, b_dout;
    logic [2:0]  b_af, b_ae, b_lvl;
    // DUT C: depth 8, first-word-fall-through
    logic        c_rst, c_wr, c_rd, c_rv, c_ack, c_ovf, c_udf, c_full, c_empty, c_afull, c_aempty;
    logic [15:0] c_din, c_dout;
    logic [3:0]  c_af, c_ae, c_lvl;

    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(0)) u_a (
        .clk(clk), .rst(a_rst), .data_in(a_din), .wr_en(a_wr), .rd_en(a_rd),
        .af_thresh(a_af), .ae_thresh(a_ae), .data_out(a_dout), .rd_valid(a_rv),
        .wr_ack(a_ack), .overflow(a_ovf), .underflow(a_udf), .full(a_full), .empty(a_empty),
        .almostfull(a_afull), .almostempty(a_aempty), .level(a_lvl));

    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .FWFT(0)) u_b (
        .clk(clk), .rst(b_rst), .data_in(b_din), .wr_en(b_wr), .rd_en(b_rd),
        .af_thresh(b_af), .ae_thresh(b_ae), .data_out(b_dout), .rd_valid(b_rv),
        .wr_ack(b_ack), .overflow(b_ovf), .underflow(b_udf), .full(b_full), .empty(b_empty),
        .almostfull(b_afull), .almostempty(b_aempty), .level(b_lvl));

    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1)) u_c (
        .clk(clk), .rst(c_rst), .data_in(c_din), .wr_en(c_wr), .rd_en(c_rd),
        .af_thresh(c_af), .ae_thresh(c_ae), .data_out(c_dout), .rd_valid(c_rv),
        .wr_ack(c_ack), .overflow(c_ovf), .underflow(c_udf), .full(c_full), .empty(c_empty),
        .almostfull(c_afull), .almostempty(c_aempty), .level(c_lvl));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [1:0]  b_ops [12];
    logic [15:0] q [$];
    logic [15:0] exp_pop;
    logic        exp_wacc, exp_racc;

    initial begin
        a_rst = 1; a_din = '0; a_wr = 1; a_rd = 1; a_af = 4'd6; a_ae = 4'd2;
        b_rst = 1; b_din = '0; b_wr = 0; b_rd = 0; b_af = 3'd5; b_ae = 3'd0;
        c_rst = 1; c_din = '0; c_wr = 0; c_rd = 0; c_af = 4'd8; c_ae = 4'd0;
        b_ops = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                  2'b01, 2'b01, 2'b11, 2'b10, 2'b11, 2'b01};

        // Reset, with wr/rd held high on DUT A to show reset wins
        tick(); tick();
        chk("a_rst_level", a_lvl, 0);
        chk("a_rst_empty", a_empty, 1);
        chk("a_rst_full", a_full, 0);
        chk("a_rst_dout", a_dout, 0);
        chk("a_rst_rvalid", a_rv, 0);
        chk("a_rst_ack", a_ack, 0);
        chk("b_rst_empty", b_empty, 1);
        chk("c_rst_dout", c_dout, 0);
        chk("c_rst_rvalid", c_rv, 0);
        a_rst = 0; b_rst = 0; c_rst = 0; a_wr = 0; a_rd = 0;

        // Fill DUT A with 1..8
        for (int i = 1; i <= 8; i++) begin
            a_din = 16'(i); a_wr = 1;
            tick();
            chk($sformatf("a_fill_ack%0d", i), a_ack, 1);
            chk($sformatf("a_fill_lvl%0d", i), a_lvl, i);
            chk($sformatf("a_fill_ae%0d", i), a_aempty, (i <= 2) ? 1 : 0);
            chk($sformatf("a_fill_af%0d", i), a_afull, (i >= 6) ? 1 : 0);
        end
        chk("a_full", a_full, 1);

        // Ninth write is rejected
        a_din = 16'h0009;
        tick();
        chk("a_ovf", a_ovf, 1);
        chk("a_ovf_ack", a_ack, 0);
        chk("a_ovf_lvl", a_lvl, 8);

        // Simultaneous write and read at full
        a_din = 16'h00AA; a_rd = 1;
        tick();
        chk("a_both_dout", a_dout, 16'h0001);
        chk("a_both_rv", a_rv, 1);
        chk("a_both_lvl", a_lvl, 8);
        chk("a_both_ovf", a_ovf, 0);
        chk("a_both_ack", a_ack, 1);

        // Drain: 2..8 then 0x00AA
        a_wr = 0;
        for (int j = 0; j < 8; j++) begin
            tick();
            chk($sformatf("a_drain_dout%0d", j), a_dout, (j < 7) ? 32'(j + 2) : 32'h00AA);
            chk($sformatf("a_drain_rv%0d", j), a_rv, 1);
        end
        chk("a_drain_empty", a_empty, 1);

        // Write and read together on empty
        a_wr = 1; a_rd = 1; a_din = 16'h0055;
        tick();
        chk("a_udf", a_udf, 1);
        chk("a_udf_lvl", a_lvl, 1);
        chk("a_udf_ack", a_ack, 1);
        chk("a_udf_rv", a_rv, 0);
        a_wr = 0;
        tick();
        chk("a_udf_read", a_dout, 16'h0055);
        chk("a_udf_read_rv", a_rv, 1);
        chk("a_udf_clear", a_udf, 0);
        a_rd = 0;
        tick();
        chk("a_hold_rv", a_rv, 0);
        chk("a_hold_dout", a_dout, 16'h0055);

        // Thresholds: fill to 6, then move thresholds without clocking
        for (int i = 0; i < 6; i++) begin
            a_din = 16'(16'h0010 + i); a_wr = 1;
            tick();
        end
        a_wr = 0;
        chk("a_th_lvl", a_lvl, 6);
        chk("a_th_af6", a_afull, 1);
        a_af = 4'd7; #1;
        chk("a_th_af7", a_afull, 0);
        a_af = 4'd0; #1;
        chk("a_th_af0", a_afull, 1);
        chk("a_th_ae2", a_aempty, 0);
        a_ae = 4'd8; #1;
        chk("a_th_ae8", a_aempty, 1);
        a_af = 4'd6; a_ae = 4'd2;

        // Reset in the middle of filling
        a_wr = 1; a_din = 16'h0077; a_rst = 1;
        tick();
        chk("a_mrst_lvl", a_lvl, 0);
        chk("a_mrst_empty", a_empty, 1);
        chk("a_mrst_full", a_full, 0);
        chk("a_mrst_ack", a_ack, 0);
        chk("a_mrst_dout", a_dout, 0);
        a_rst = 0; a_din = 16'h0099;
        tick();
        chk("a_post_ack", a_ack, 1);
        chk("a_post_lvl", a_lvl, 1);
        a_wr = 0; a_rd = 1;
        tick();
        chk("a_post_dout", a_dout, 16'h0099);
        chk("a_post_rv", a_rv, 1);
        a_rd = 0;

        // DUT B: interleaved traffic on a depth-5 FIFO against a queue model
        for (int k = 0; k < 12; k++) begin
            b_wr = b_ops[k][1]; b_rd = b_ops[k][0]; b_din = 16'(16'h0100 + k);
            exp_racc = b_rd && (q.size() > 0);
            exp_wacc = b_wr && ((q.size() < 5) || exp_racc);
            exp_pop  = '0;
            if (exp_racc) exp_pop = q.pop_front();
            if (exp_wacc) q.push_back(b_din);
            tick();
            chk($sformatf("b_lvl%0d", k), b_lvl, q.size());
            chk($sformatf("b_ack%0d", k), b_ack, exp_wacc);
            chk($sformatf("b_ovf%0d", k), b_ovf, b_wr && !exp_wacc);
            if (exp_racc) chk($sformatf("b_dout%0d", k), b_dout, exp_pop);
        end
        b_wr = 0; b_rd = 1;
        for (int k = 0; k < 3; k++) begin
            exp_pop = q.pop_front();
            tick();
            chk($sformatf("b_drain%0d", k), b_dout, exp_pop);
        end
        chk("b_drain_empty", b_empty, 1);
        b_rd = 0;

        // DUT C: first-word-fall-through
        c_din = 16'h1234; c_wr = 1;
        tick();
        c_wr = 0;
        chk("c_fwft_dout", c_dout, 16'h1234);
        chk("c_fwft_rv", c_rv, 1);
        chk("c_fwft_empty", c_empty, 0);
        tick();
        chk("c_fwft_hold", c_dout, 16'h1234);
        c_rd = 1;
        tick();
        c_rd = 0;
        chk("c_pop_empty", c_empty, 1);
        chk("c_pop_rv", c_rv, 0);
        c_din = 16'hAAAA; c_wr = 1;
        tick();
        c_din = 16'hBBBB;
        tick();
        c_wr = 0;
        chk("c_head1", c_dout, 16'hAAAA);
        chk("c_lvl2", c_lvl, 2);
        c_rd = 1;
        tick();
        c_rd = 0;
        chk("c_head2", c_dout, 16'hBBBB);
        chk("c_lvl1", c_lvl, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
